zmc_sync: RTL and testbench

ZMC_SYNC -- requirements
Module: zmc_sync

---
 rtl/zmc_sync_if.sv | 22 ++
 rtl/zmc_sync.sv | 89 ++++++++
 tb/tb_zmc_sync.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/zmc_sync_if.sv
// Z80 bank-select / ROM fetch bus for zmc_sync.
//   SDRD0   : async bank-write strobe (rising edge commits)
//   SDA_L   : Z80 A[1:0], bank register select
//   SDA_U   : Z80 A[15:8], bank data on write, window address on fetch
//   MA      : registered ROM address bits [ROM_AW-1:11]
//   BANK_WR : one-cycle pulse after a bank register update
//   WR_OVF  : sticky, a written bank value exceeded the ROM size
interface zmc_sync_if #(
    parameter int unsigned ROM_AW = 22
);
    localparam int unsigned MA_W = ROM_AW - 11;

    logic            SDRD0;
    logic [1:0]      SDA_L;
    logic [7:0]      SDA_U;
    logic [MA_W-1:0] MA;
    logic            BANK_WR;
    logic            WR_OVF;

    modport master (output SDRD0, SDA_L, SDA_U, input MA, BANK_WR, WR_OVF);
    modport slave  (input SDRD0, SDA_L, SDA_U, output MA, BANK_WR, WR_OVF);
endinterface

// File: rtl/zmc_sync.sv
// Z80 M1 ROM bank mapper with SDRD0 synchronizer.
//   CLK   : system clock, rising edge
//   RESET : synchronous, active-high
//   bus   : zmc_sync_if.slave (SDRD0/SDA_L/SDA_U in, MA/BANK_WR/WR_OVF out)
// Four bank registers map the 8000-FFFF windows; 0000-7FFF passes through.
module zmc_sync #(
    parameter int unsigned BANK_W      = 8,
    parameter int unsigned ROM_AW      = 22,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    zmc_sync_if.slave  bus
);
    localparam int unsigned MA_W  = ROM_AW - 11;
    localparam int unsigned EXT_W = BANK_W + 3;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [3:0][BANK_W-1:0] bank_q, bank_d;
    logic [MA_W-1:0]        ma_q, ma_d;
    logic                   bank_wr_q, bank_wr_d;
    logic                   wr_ovf_q, wr_ovf_d;

    logic              wr_ev;
    logic [BANK_W-1:0] wr_data;
    logic [EXT_W-1:0]  ovf_ext;

    // Synchronizer shift plus one history flop for rising-edge detect.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.SDRD0};
        hist_d = sync_q[SYNC_STAGES-1];
        wr_ev  = sync_q[SYNC_STAGES-1] & ~hist_q;
    end

    // Bank write and overflow: value shifted by its window's shift must fit MA_W.
    always_comb begin
        wr_data = BANK_W'(bus.SDA_U);
        ovf_ext = EXT_W'(wr_data) << bus.SDA_L;
        bank_d  = bank_q;
        if (wr_ev) begin
            bank_d[bus.SDA_L] = wr_data;
        end
        bank_wr_d = wr_ev;
        wr_ovf_d  = wr_ovf_q | (wr_ev & ((ovf_ext >> MA_W) != '0));
    end

    // Window decode uses the pre-write bank value; truncation wraps modulo ROM size.
    always_comb begin
        ma_d = '0;
        if (!bus.SDA_U[7]) begin
            ma_d = MA_W'(bus.SDA_U[7:3]);
        end else if (!bus.SDA_U[6]) begin
            ma_d = MA_W'({bank_q[3], bus.SDA_U[5:3]});
        end else if (!bus.SDA_U[5]) begin
            ma_d = MA_W'({bank_q[2], bus.SDA_U[4:3]});
        end else if (!bus.SDA_U[4]) begin
            ma_d = MA_W'({bank_q[1], bus.SDA_U[3]});
        end else begin
            ma_d = MA_W'(bank_q[0]);
        end
    end

    // Reset loads the synchronizer high so a held strobe cannot fake an edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q    <= '1;
            hist_q    <= 1'b1;
            bank_q[0] <= BANK_W'(8'h1E);
            bank_q[1] <= BANK_W'(8'h0E);
            bank_q[2] <= BANK_W'(8'h06);
            bank_q[3] <= BANK_W'(8'h02);
            ma_q      <= '0;
            bank_wr_q <= 1'b0;
            wr_ovf_q  <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            hist_q    <= hist_d;
            bank_q    <= bank_d;
            ma_q      <= ma_d;
            bank_wr_q <= bank_wr_d;
            wr_ovf_q  <= wr_ovf_d;
        end
    end

    assign bus.MA      = ma_q;
    assign bus.BANK_WR = bank_wr_q;
    assign bus.WR_OVF  = wr_ovf_q;
endmodule

// File: tb/tb_zmc_sync.sv
// Self-checking bench for zmc_sync: instance A uses defaults, instance B uses
// ROM_AW=19 / SYNC_STAGES=3; both see the same stimulus.
module tb_zmc_sync;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    zmc_sync_if #(.ROM_AW(22)) bus_a ();
    zmc_sync_if #(.ROM_AW(19)) bus_b ();

    zmc_sync #(.BANK_W(8), .ROM_AW(22), .SYNC_STAGES(2)) dut_a (
        .CLK(clk), .RESET(rst), .bus(bus_a)
    );
    zmc_sync #(.BANK_W(8), .ROM_AW(19), .SYNC_STAGES(3)) dut_b (
        .CLK(clk), .RESET(rst), .bus(bus_b)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state per instance
    longint m_bank [2][4];
    int     m_hist [2][5];   // effective SDRD0 samples, [0] = most recent edge
    longint m_ma   [2];
    int     m_wr   [2];
    int     m_ovf  [2];
    int     wr_cnt [2];

    function automatic int stages(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int maw(input int d);
        return (d == 0) ? 11 : 8;
    endfunction

    function automatic longint map_fn(input int d, input logic [7:0] u);
        longint v;
        longint hi = longint'(u) / 8;  // Z80 A[15:11]
        if (u < 8'h80)      v = hi;
        else if (u < 8'hC0) v = m_bank[d][3] * 8 + hi % 8;
        else if (u < 8'hE0) v = m_bank[d][2] * 4 + hi % 4;
        else if (u < 8'hF0) v = m_bank[d][1] * 2 + hi % 2;
        else                v = m_bank[d][0];
        return v % (longint'(1) << maw(d));
    endfunction

    task automatic predict(input int d, input logic r, input logic sd,
                           input logic [1:0] sl, input logic [7:0] su);
        int ev;
        if (r) begin
            m_bank[d][0] = 'h1E; m_bank[d][1] = 'h0E;
            m_bank[d][2] = 'h06; m_bank[d][3] = 'h02;
            m_ma[d] = 0; m_wr[d] = 0; m_ovf[d] = 0;
            for (int i = 0; i < 5; i++) m_hist[d][i] = 1;
        end else begin
            ev = (m_hist[d][stages(d)-1] == 1 && m_hist[d][stages(d)] == 0) ? 1 : 0;
            m_ma[d] = map_fn(d, su);
            if (ev == 1) begin
                m_bank[d][sl] = longint'(su);
                if (longint'(su) * (longint'(1) << sl) >= (longint'(1) << maw(d)))
                    m_ovf[d] = 1;
            end
            m_wr[d] = ev;
            for (int i = 4; i > 0; i--) m_hist[d][i] = m_hist[d][i-1];
            m_hist[d][0] = sd ? 1 : 0;
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic step(input logic r, input logic sd,
                        input logic [1:0] sl, input logic [7:0] su);
        rst = r;
        bus_a.SDRD0 = sd; bus_a.SDA_L = sl; bus_a.SDA_U = su;
        bus_b.SDRD0 = sd; bus_b.SDA_L = sl; bus_b.SDA_U = su;
        for (int d = 0; d < 2; d++) predict(d, r, sd, sl, su);
        @(posedge clk);
        #1;
        chk("a_ma",  longint'(bus_a.MA),      m_ma[0]);
        chk("a_wr",  longint'(bus_a.BANK_WR), longint'(m_wr[0]));
        chk("a_ovf", longint'(bus_a.WR_OVF),  longint'(m_ovf[0]));
        chk("b_ma",  longint'(bus_b.MA),      m_ma[1]);
        chk("b_wr",  longint'(bus_b.BANK_WR), longint'(m_wr[1]));
        chk("b_ovf", longint'(bus_b.WR_OVF),  longint'(m_ovf[1]));
        wr_cnt[0] += int'(bus_a.BANK_WR);
        wr_cnt[1] += int'(bus_b.BANK_WR);
    endtask

    typedef struct {
        logic        rst;
        logic        sd;
        logic [1:0]  sl;
        logic [7:0]  su;
        logic [10:0] ma;
        logic        wr;
        logic        ovf;
    } vec_t;

    vec_t tbl [17];
    logic sdv;

    initial begin
        bus_a.SDRD0 = 1'b0; bus_a.SDA_L = '0; bus_a.SDA_U = '0;
        bus_b.SDRD0 = 1'b0; bus_b.SDA_L = '0; bus_b.SDA_U = '0;

        // Expected values for instance A after each edge
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 8'h00, 11'h000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2'd0, 8'h00, 11'h000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 8'hF0, 11'h01E, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 2'd0, 8'hE8, 11'h01D, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 2'd0, 8'hC8, 11'h019, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 2'd0, 8'h90, 11'h012, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 2'd0, 8'h3F, 11'h007, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 2'd3, 8'h25, 11'h004, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 2'd3, 8'h25, 11'h004, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 2'd3, 8'h25, 11'h004, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 2'd3, 8'h88, 11'h129, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 2'd3, 8'h88, 11'h129, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 2'd2, 8'hC0, 11'h018, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 2'd2, 8'hC0, 11'h018, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 2'd2, 8'h10, 11'h002, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 2'd2, 8'hC0, 11'h040, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 2'd2, 8'hC0, 11'h040, 1'b0, 1'b0};

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rst, tbl[i].sd, tbl[i].sl, tbl[i].su);
            chk($sformatf("tbl%0d_ma", i),  longint'(bus_a.MA),      longint'(tbl[i].ma));
            chk($sformatf("tbl%0d_wr", i),  longint'(bus_a.BANK_WR), longint'(tbl[i].wr));
            chk($sformatf("tbl%0d_ovf", i), longint'(bus_a.WR_OVF),  longint'(tbl[i].ovf));
        end

        // SDRD0 held high through reset release: no write until low then high
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd0, 8'hF0);
        wr_cnt[0] = 0; wr_cnt[1] = 0;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'd0, 8'h90);
        chk("hold_wr_a", longint'(wr_cnt[0]), 0);
        chk("hold_wr_b", longint'(wr_cnt[1]), 0);
        chk("hold_ma_a", longint'(bus_a.MA), 'h12);
        wr_cnt[0] = 0; wr_cnt[1] = 0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'd0, 8'hF0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'd0, 8'hF0);
        chk("rise_wr_a", longint'(wr_cnt[0]), 1);
        chk("rise_wr_b", longint'(wr_cnt[1]), 1);

        // Reset during an in-flight edge cancels the write
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 2'd0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'd0, 8'h00);
        wr_cnt[0] = 0; wr_cnt[1] = 0;
        step(1'b0, 1'b1, 2'd0, 8'h55);
        step(1'b1, 1'b1, 2'd0, 8'h55);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'd0, 8'hF0);
        chk("cancel_wr_a", longint'(wr_cnt[0]), 0);
        chk("cancel_wr_b", longint'(wr_cnt[1]), 0);
        chk("cancel_ma_a", longint'(bus_a.MA), 'h1E);

        // Overflow on the small-ROM instance, with wrap-around fetch
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 2'd0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'd0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'd3, 8'h40);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 2'd3, 8'h80);
        chk("wrap_ma_b",  longint'(bus_b.MA), 'h000);
        chk("wrap_ovf_b", longint'(bus_b.WR_OVF), 1);
        chk("wrap_ma_a",  longint'(bus_a.MA), 'h200);
        chk("wrap_ovf_a", longint'(bus_a.WR_OVF), 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'd0, 8'hF0);
        chk("sticky_ovf_b", longint'(bus_b.WR_OVF), 1);

        // Randomized traffic against the model
        sdv = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) sdv = ~sdv;
            step(($urandom_range(0, 299) == 0), sdv,
                 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
